// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_pkg
// Description : Shared widths, default memory size and fetch FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

    localparam int INSTR_W           = 32;
    localparam int ADDR_W            = 32;
    localparam int MEM_BYTES_DEFAULT = 32;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry {pc, instr} buffer with push, pop, flush and count.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = ADDR_W + INSTR_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A flush discards everything, including a same-cycle push or pop.
    assign do_pop  = pop_i && !flush_i && !empty_o;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch FSM and PC generator feeding a fetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int                DEPTH     = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  PC,
    input  logic [INSTR_W-1:0] Instruction_Code,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               misalign_err
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_BYTES - 1);
    localparam logic [ADDR_W-1:0] MEM_END   = ADDR_W'(MEM_BYTES);
    localparam int                CNT_W     = $clog2(DEPTH) + 1;

    fetch_state_e               state_q;
    logic [ADDR_W-1:0]          fetch_pc_q;
    logic [ADDR_W-1:0]          fetch_pc_d;
    logic [ADDR_W-1:0]          fetch_pc_inc;
    logic                       misalign_err_q;
    logic [CNT_W-1:0]           count;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       flush;
    logic                       misaligned;
    logic [ADDR_W+INSTR_W-1:0]  head;

    assign misaligned   = (redirect_pc[1:0] != 2'b00);
    assign flush        = (state_q == RUN) && redirect_valid;
    assign pop          = out_ready && !empty;
    assign push         = (state_q == RUN) && !redirect_valid && (!full || pop);
    assign fetch_pc_inc = fetch_pc_q + 32'd4;
    assign fetch_pc_d   = (fetch_pc_inc == MEM_END) ? '0 : fetch_pc_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= INIT;
            fetch_pc_q     <= RESET_PC;
            misalign_err_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: state_q <= RUN;
                RUN: begin
                    if (redirect_valid) begin
                        // A misaligned target freezes the fetch address for post-mortem.
                        if (misaligned) begin
                            state_q        <= ERR;
                            misalign_err_q <= 1'b1;
                        end else begin
                            fetch_pc_q <= redirect_pc & ADDR_MASK;
                        end
                    end else if (push) begin
                        fetch_pc_q <= fetch_pc_d;
                    end
                end
                ERR:     state_q <= ERR;
                default: state_q <= INIT;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ADDR_W + INSTR_W)
    ) u_fetch_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  ({fetch_pc_q, Instruction_Code}),
        .data_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign PC           = fetch_pc_q;
    assign out_valid    = (count != '0);
    assign out_pc       = head[ADDR_W+INSTR_W-1:INSTR_W];
    assign out_instr    = head[INSTR_W-1:0];
    assign misalign_err = misalign_err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench: queue-based fetch model plus directed cases.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_inst_fetch;

    localparam int          MEMB   = 32;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        out_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc_w;
    logic [31:0] instr_code;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_valid;
    logic        misalign_err;
    logic [31:0] mem [0:7];

    int checks = 0;
    int errors = 0;

    // Model state: mode 0 = waiting one cycle after reset, 1 = fetching, 2 = stopped
    int          mode;
    logic [31:0] m_pc;
    logic        m_err;
    logic [63:0] mq[$];
    bit          live = 1'b0;
    bit          m_pop;
    bit          m_push;

    always #5 clk = ~clk;

    assign instr_code = mem[pc_w[4:2]];

    inst_fetch #(
        .RESET_PC  (RST_PC),
        .MEM_BYTES (MEMB),
        .DEPTH     (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .PC               (pc_w),
        .Instruction_Code (instr_code),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_pc           (out_pc),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .misalign_err     (misalign_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        mode  = 0;
        m_pc  = RST_PC;
        m_err = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                mode  = 0;
                m_pc  = RST_PC;
                m_err = 1'b0;
                mq.delete();
            end else if (mode == 0) begin
                mode = 1;
            end else if (mode == 1) begin
                if (redirect_valid) begin
                    mq.delete();
                    if (redirect_pc % 4 != 0) begin
                        mode  = 2;
                        m_err = 1'b1;
                    end else begin
                        m_pc = redirect_pc % MEMB;
                    end
                end else begin
                    m_pop  = (mq.size() > 0) && out_ready;
                    m_push = (mq.size() < DEPTH) || m_pop;
                    if (m_pop) void'(mq.pop_front());
                    if (m_push) begin
                        mq.push_back({m_pc, mem[m_pc / 4]});
                        m_pc = (m_pc + 4) % MEMB;
                    end
                end
            end
            live = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                check("model_PC", pc_w, m_pc);
                check("model_out_valid", 32'(out_valid), 32'(mq.size() != 0));
                check("model_misalign_err", 32'(misalign_err), 32'(m_err));
                if (mq.size() != 0) begin
                    check("model_out_pc", out_pc, mq[0][63:32]);
                    check("model_out_instr", out_instr, mq[0][31:0]);
                end
            end
        end
    end

    initial begin
        bit found;
        mem[0] = 32'h3094_0333;
        mem[1] = 32'h20A5_8633;
        mem[2] = 32'h035A_02B3;
        for (int i = 3; i < 8; i++) mem[i] = 32'h0000_0013 | (i << 20);
        reset          = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset for three cycles, then the first three instructions stream out.
        repeat (3) cyc();
        check("rst_PC", pc_w, 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_err", 32'(misalign_err), 32'h0);
        reset = 1'b0;
        cyc();
        check("lat_edge1_valid", 32'(out_valid), 32'h0);
        cyc();
        check("lat_edge2_valid", 32'(out_valid), 32'h1);
        check("first_pc", out_pc, 32'h0);
        check("first_instr", out_instr, 32'h3094_0333);
        cyc();
        check("second_pc", out_pc, 32'h4);
        check("second_instr", out_instr, 32'h20A5_8633);
        cyc();
        check("third_pc", out_pc, 32'h8);
        check("third_instr", out_instr, 32'h035A_02B3);

        // Back-pressure: buffer fills to two entries and the head stays put.
        reset     = 1'b1;
        out_ready = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        check("bp_first_valid", 32'(out_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_hold_instr", out_instr, 32'h3094_0333);
            check("bp_hold_valid", 32'(out_valid), 32'h1);
        end
        check("bp_PC_hold", pc_w, 32'h8);

        // Address wrap at the end of memory.
        out_ready = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (out_valid && out_pc == 32'd24) found = 1'b1;
        end
        check("wrap_reach_24", 32'(found), 32'h1);
        cyc();
        check("wrap_pc_28", out_pc, 32'd28);
        cyc();
        check("wrap_pc_0", out_pc, 32'd0);
        check("wrap_instr_0", out_instr, 32'h3094_0333);

        // Aligned redirect while full and draining.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        cyc();
        check("redir_bubble_valid", 32'(out_valid), 32'h0);
        check("redir_PC", pc_w, 32'h10);
        redirect_valid = 1'b0;
        cyc();
        check("redir_target_valid", 32'(out_valid), 32'h1);
        check("redir_target_pc", out_pc, 32'h10);
        check("redir_target_instr", out_instr, 32'h0040_0013);

        // Misaligned redirect locks the fetch unit until reset.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        cyc();
        check("mis_err", 32'(misalign_err), 32'h1);
        check("mis_valid", 32'(out_valid), 32'h0);
        check("mis_PC_hold", pc_w, 32'h14);
        redirect_pc = 32'h0;
        cyc();
        cyc();
        check("err_ignore_redir_PC", pc_w, 32'h14);
        check("err_ignore_valid", 32'(out_valid), 32'h0);
        check("err_sticky", 32'(misalign_err), 32'h1);
        redirect_valid = 1'b0;

        // Reset while full with a simultaneous redirect.
        reset = 1'b1;
        cyc();
        reset     = 1'b0;
        out_ready = 1'b0;
        repeat (3) cyc();
        check("pre_rst_full_valid", 32'(out_valid), 32'h1);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        out_ready      = 1'b1;
        cyc();
        check("rst_ovr_PC", pc_w, RST_PC);
        check("rst_ovr_valid", 32'(out_valid), 32'h0);
        check("rst_ovr_err", 32'(misalign_err), 32'h0);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        cyc();
        cyc();
        check("restart_pc", out_pc, RST_PC);
        check("restart_instr", out_instr, 32'h3094_0333);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            reset          = ($urandom_range(0, 149) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 9) == 0)
                redirect_pc = ($urandom & 32'hFC) | 32'($urandom_range(1, 3));
            else
                redirect_pc = $urandom & 32'hFC;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
